// File: rtl/tcam_16x8.sv
// tcam_16x8: 16 x 8 binary CAM with per-bit write mask, per-entry valid and masked compare.
// Optional lowest-index hit address output HITA is enabled by defining TCAM_HIT_ADDR_EN.
module tcam_16x8 #(
    parameter int WORDS  = 16,
    parameter int BITS   = 8,
    parameter int ADDR_W = 4,
    parameter int BANKS  = 1
) (
    input  logic              CK,
    input  logic              RST_N,
    input  logic              CS,
    input  logic              FLUSH,
    input  logic              VBE,
    input  logic              DCS,
    input  logic              WR,
    input  logic              RD,
    input  logic              CMP,
    input  logic [BITS-1:0]   DI,
    input  logic [BITS-1:0]   MSKB,
    input  logic              VBI,
    input  logic [ADDR_W-1:0] A,
    input  logic [BANKS-1:0]  CBE,
    output logic [BITS-1:0]   DO,
    output logic              VBO,
    output logic              HIT,
    output logic [WORDS-1:0]  HITLINE
`ifdef TCAM_HIT_ADDR_EN
    ,
    output logic [ADDR_W-1:0] HITA
`endif
);

    localparam int BANK_SZ = WORDS / BANKS;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_FLUSH,
        OP_WR,
        OP_RD,
        OP_CMP
    } op_e;

    logic [BITS-1:0]  data [WORDS];
    logic [WORDS-1:0] valid;
    logic [WORDS-1:0] hit_c;
    logic             addr_ok;
    op_e              op;

    // Zero-extend so the bound check stays meaningful for non-power-of-2 depths.
    assign addr_ok = {1'b0, A} < (ADDR_W + 1)'(WORDS);

    always_comb begin
        op = OP_NONE;
        if (CS) begin
            if (FLUSH)    op = OP_FLUSH;
            else if (WR)  op = OP_WR;
            else if (RD)  op = OP_RD;
            else if (CMP) op = OP_CMP;
        end
    end

    for (genvar i = 0; i < WORDS; i++) begin : g_cmp
        assign hit_c[i] = valid[i]
                        & ~CBE[i / BANK_SZ]
                        & (((data[i] ^ DI) & MSKB) == '0);
    end

`ifdef TCAM_HIT_ADDR_EN
    logic [ADDR_W-1:0] hita_c;

    // Scan from the top so the lowest matching index wins.
    always_comb begin
        hita_c = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (hit_c[i]) hita_c = ADDR_W'(i);
        end
    end
`endif

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < WORDS; i++) data[i] <= '0;
            valid   <= '0;
            DO      <= '0;
            VBO     <= 1'b0;
            HIT     <= 1'b0;
            HITLINE <= '0;
`ifdef TCAM_HIT_ADDR_EN
            HITA    <= '0;
`endif
        end else begin
            unique case (op)
                OP_FLUSH: begin
                    valid   <= '0;
                    HIT     <= 1'b0;
                    HITLINE <= '0;
`ifdef TCAM_HIT_ADDR_EN
                    HITA    <= '0;
`endif
                end
                OP_WR: begin
                    if (addr_ok) begin
                        if (DCS) data[A] <= (data[A] & ~MSKB) | (DI & MSKB);
                        if (VBE) valid[A] <= VBI;
                    end
                end
                OP_RD: begin
                    if (DCS) DO <= addr_ok ? data[A] : '0;
                    if (VBE) VBO <= addr_ok & valid[A];
                end
                OP_CMP: begin
                    HITLINE <= hit_c;
                    HIT     <= |hit_c;
`ifdef TCAM_HIT_ADDR_EN
                    HITA    <= hita_c;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tcam_16x8.sv
// Directed bench for tcam_16x8: hand-computed vectors checked with immediate assertions.
// HITA checks are included only when TCAM_HIT_ADDR_EN is defined.
module tb_tcam_16x8;

    logic        CK;
    logic        RST_N;
    logic        CS, FLUSH, VBE, DCS, WR, RD, CMP, VBI;
    logic [7:0]  DI, MSKB, DO;
    logic [3:0]  A;
    logic [0:0]  CBE;
    logic        VBO, HIT;
    logic [15:0] HITLINE;
`ifdef TCAM_HIT_ADDR_EN
    logic [3:0]  HITA;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    tcam_16x8 dut (
        .CK(CK), .RST_N(RST_N), .CS(CS), .FLUSH(FLUSH), .VBE(VBE),
        .DCS(DCS), .WR(WR), .RD(RD), .CMP(CMP), .DI(DI), .MSKB(MSKB),
        .VBI(VBI), .A(A), .CBE(CBE), .DO(DO), .VBO(VBO), .HIT(HIT),
        .HITLINE(HITLINE)
`ifdef TCAM_HIT_ADDR_EN
        , .HITA(HITA)
`endif
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_hita(input string tag, input logic [3:0] exp);
`ifdef TCAM_HIT_ADDR_EN
        chk(tag, 32'(HITA), 32'(exp));
`else
        if (exp === 4'hx) $display("unused %s", tag);
`endif
    endtask

    // One clock with the given strobes; outputs sampled 1 ns after the edge.
    task automatic op(input logic cs, input logic fl, input logic wr,
                      input logic rd, input logic cmp, input logic [3:0] a,
                      input logic [7:0] di, input logic [7:0] msk,
                      input logic vbi, input logic vbe, input logic dcs,
                      input logic cbe);
        CS = cs; FLUSH = fl; WR = wr; RD = rd; CMP = cmp; A = a;
        DI = di; MSKB = msk; VBI = vbi; VBE = vbe; DCS = dcs; CBE = cbe;
        @(posedge CK);
        #1;
        CS = 1'b0; FLUSH = 1'b0; WR = 1'b0; RD = 1'b0; CMP = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] di,
                      input logic [7:0] msk, input logic vbi,
                      input logic vbe, input logic dcs);
        op(1, 0, 1, 0, 0, a, di, msk, vbi, vbe, dcs, 0);
    endtask

    task automatic rd(input logic [3:0] a);
        op(1, 0, 0, 1, 0, a, 8'h00, 8'h00, 0, 1, 1, 0);
    endtask

    task automatic cmp(input logic [7:0] di, input logic [7:0] msk,
                       input logic cbe);
        op(1, 0, 0, 0, 1, 4'd0, di, msk, 0, 0, 0, cbe);
    endtask

    initial begin
        RST_N = 1'b0;
        CS = 0; FLUSH = 0; VBE = 0; DCS = 0; WR = 0; RD = 0; CMP = 0;
        VBI = 0; DI = '0; MSKB = '0; A = '0; CBE = '0;
        #2;
        chk("rst_do", 32'(DO), 32'h00);
        chk("rst_vbo", 32'(VBO), 32'h0);
        chk("rst_hit", 32'(HIT), 32'h0);
        chk("rst_hitline", 32'(HITLINE), 32'h0000);
        chk_hita("rst_hita", 4'd0);
        #1 RST_N = 1'b1;

        rd(4'd3);
        chk("rd3_do", 32'(DO), 32'h00);
        chk("rd3_vbo", 32'(VBO), 32'h0);
        cmp(8'h00, 8'hFF, 1'b0);
        chk("cmp_empty_hit", 32'(HIT), 32'h0);
        chk("cmp_empty_line", 32'(HITLINE), 32'h0000);

        wr(4'd5, 8'h3A, 8'hFF, 1, 1, 1);
        chk("wr5_hold_hit", 32'(HIT), 32'h0);
        cmp(8'h30, 8'hF0, 1'b0);
        chk("cmp5_hit", 32'(HIT), 32'h1);
        chk("cmp5_line", 32'(HITLINE), 32'h0020);
        chk_hita("cmp5_hita", 4'd5);
        rd(4'd5);
        chk("rd5_do", 32'(DO), 32'h3A);
        chk("rd5_vbo", 32'(VBO), 32'h1);

        wr(4'd5, 8'h00, 8'h0F, 0, 0, 1);
        rd(4'd5);
        chk("bitwr_do", 32'(DO), 32'h30);
        chk("bitwr_vbo", 32'(VBO), 32'h1);

        wr(4'd2, 8'h71, 8'hFF, 1, 1, 1);
        wr(4'd9, 8'h7C, 8'hFF, 1, 1, 1);
        cmp(8'h70, 8'hF0, 1'b0);
        chk("multi_line", 32'(HITLINE), 32'h0204);
        chk("multi_hit", 32'(HIT), 32'h1);
        chk_hita("multi_hita", 4'd2);
        cmp(8'h70, 8'hF0, 1'b1);
        chk("cbe_line", 32'(HITLINE), 32'h0000);
        chk("cbe_hit", 32'(HIT), 32'h0);
        chk_hita("cbe_hita", 4'd0);
        cmp(8'h55, 8'h00, 1'b0);
        chk("nomask_line", 32'(HITLINE), 32'h0224);
        chk("nomask_hit", 32'(HIT), 32'h1);

        op(1, 1, 1, 1, 1, 4'd2, 8'h00, 8'hFF, 0, 1, 1, 0);
        chk("flush_hit", 32'(HIT), 32'h0);
        chk("flush_line", 32'(HITLINE), 32'h0000);
        chk_hita("flush_hita", 4'd0);
        chk("flush_do_hold", 32'(DO), 32'h30);
        chk("flush_vbo_hold", 32'(VBO), 32'h1);
        cmp(8'h70, 8'hF0, 1'b0);
        chk("postflush_line", 32'(HITLINE), 32'h0000);
        rd(4'd2);
        chk("postflush_vbo", 32'(VBO), 32'h0);
        chk("postflush_do", 32'(DO), 32'h71);

        wr(4'd2, 8'h71, 8'hFF, 1, 1, 1);
        cmp(8'h70, 8'hF0, 1'b0);
        chk("rearm_line", 32'(HITLINE), 32'h0004);
        op(1, 0, 1, 0, 1, 4'd9, 8'h75, 8'hFF, 1, 1, 1, 0);
        chk("wrcmp_line_hold", 32'(HITLINE), 32'h0004);
        chk("wrcmp_hit_hold", 32'(HIT), 32'h1);
        rd(4'd9);
        chk("wrcmp_do", 32'(DO), 32'h75);
        chk("wrcmp_vbo", 32'(VBO), 32'h1);
        op(1, 0, 0, 1, 1, 4'd2, 8'h00, 8'h00, 0, 1, 1, 0);
        chk("rdcmp_do", 32'(DO), 32'h71);
        chk("rdcmp_line_hold", 32'(HITLINE), 32'h0004);

        op(0, 0, 1, 0, 0, 4'd2, 8'h00, 8'hFF, 0, 1, 1, 0);
        chk("cs0_do_hold", 32'(DO), 32'h71);
        op(0, 0, 0, 0, 1, 4'd0, 8'h00, 8'h00, 0, 0, 0, 0);
        chk("cs0_line_hold", 32'(HITLINE), 32'h0004);
        rd(4'd2);
        chk("cs0_mem_do", 32'(DO), 32'h71);
        chk("cs0_mem_vbo", 32'(VBO), 32'h1);

        #2 RST_N = 1'b0;
        #1;
        chk("async_do", 32'(DO), 32'h00);
        chk("async_vbo", 32'(VBO), 32'h0);
        chk("async_hit", 32'(HIT), 32'h0);
        chk("async_line", 32'(HITLINE), 32'h0000);
        #1 RST_N = 1'b1;
        rd(4'd2);
        chk("postrst_do", 32'(DO), 32'h00);
        chk("postrst_vbo", 32'(VBO), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tcam_16x8.md
Name: tcam_16x8

Overview:
- Behavioural model of a 16-word x 8-bit binary CAM macro with per-bit write mask, a per-entry valid bit and a global search mask.
- Serves the packet-ID lookup wrapper:
  - Each entry stores {PacketID[7:4], DstID[3:0]}.
  - A masked compare on the upper nibble produces a one-hot hit line.
  - A follow-up read returns the stored entry.
- All operations are synchronous to CK, gated by CS, one operation per cycle.

Parameters:
- WORDS, 16, number of entries.
- BITS, 8, entry data width.
- ADDR_W, 4, address width, log2(WORDS).
- BANKS, 1, number of compare banks; each bank covers WORDS/BANKS consecutive entries.

Ports:
- CK, input, 1, clock; all state updates on the rising edge.
- RST_N, input, 1, reset: asynchronous, active-low.
- CS, input, 1, chip select; when 0 no operation occurs and all outputs hold.
- FLUSH, input, 1, clear all valid bits.
- VBE, input, 1, valid-bit enable: write VBI on WR; drive VBO on RD.
- DCS, input, 1, data-field select: write DI on WR; drive DO on RD.
- WR, input, 1, write strobe.
- RD, input, 1, read strobe.
- CMP, input, 1, compare strobe.
- DI, input, BITS, write data or search key.
- MSKB, input, BITS, bit-mask, 1 = active bit: per-bit write enable on WR, per-bit care mask on CMP.
- VBI, input, 1, valid bit to write.
- A, input, ADDR_W, entry address for WR/RD.
- CBE, input, BANKS, active-low compare bank enable; bit b = 1 excludes bank b from compare.
- DO, output, BITS, read data.
- VBO, output, 1, read valid bit.
- HIT, output, 1, OR of HITLINE.
- HITLINE, output, WORDS, per-entry match vector, bit i = entry i.

Behaviour:
- Storage per entry: data[BITS] and valid.
- RST_N = 0, asynchronous:
  - all data = 0, all valid = 0;
  - DO = 0, VBO = 0, HIT = 0, HITLINE = 0.
- Release of RST_N is sampled synchronously; the first operation can occur on the first rising edge with RST_N = 1.
- Operation select on a rising edge with CS = 1 uses fixed priority FLUSH > WR > RD > CMP. Lower-priority strobes asserted in the same cycle are ignored.
- FLUSH:
  - all valid bits = 0; data untouched.
  - HIT and HITLINE cleared to 0 in the same edge.
  - DO and VBO hold.
- WR, entry A:
  - If DCS = 1: for each bit k with MSKB[k] = 1, data[A][k] = DI[k]; other bits keep their value.
  - If VBE = 1: valid[A] = VBI.
  - With DCS = 0 and VBE = 0, a WR is a no-op.
  - Outputs hold.
- RD, entry A, one-cycle latency (registered):
  - DO = data[A] if DCS = 1, otherwise DO holds.
  - VBO = valid[A] if VBE = 1, otherwise VBO holds.
  - A read of an address written on the previous edge returns the new value.
- CMP, one-cycle latency (registered):
  - HITLINE[i] = valid[i] AND CBE[i / (WORDS/BANKS)] == 0 AND ((data[i] XOR DI) AND MSKB) == 0.
  - HIT = OR of HITLINE.
  - MSKB = 0 matches every valid entry in enabled banks.
  - Multiple hits are all reported.
  - DO and VBO hold.
- CS = 0, or CS = 1 with no strobe: all storage and outputs hold.
- HIT and HITLINE hold until the next CMP, FLUSH or reset.
- Address A is always in range for WORDS = 2^ADDR_W. For non-power-of-2 WORDS, out-of-range WR is ignored and out-of-range RD returns DO = 0, VBO = 0.
- No X propagation: all outputs are defined from reset onward.

Optional Feature:
- Macro TCAM_HIT_ADDR_EN.
- When defined:
  - Adds output HITA [ADDR_W], registered together with HIT on CMP.
  - HITA = lowest index i with HITLINE[i] = 1, or 0 when no hit.
  - HITA resets to 0 and clears on FLUSH.
- When undefined: port HITA and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then RD A=3, VBE=1, DCS=1 -> next cycle DO=8'h00, VBO=0. Then CMP DI=8'h00, MSKB=8'hFF -> HIT=0, HITLINE=16'h0000.
- WR A=5, DI=8'h3A, MSKB=8'hFF, VBI=1, VBE=1, DCS=1. Then CMP DI=8'h30, MSKB=8'hF0, CBE=0 -> next cycle HIT=1, HITLINE=16'h0020 (HITA=5 if enabled). Then RD A=5 -> DO=8'h3A, VBO=1.
- Bit-write: WR A=5, DI=8'h00, MSKB=8'h0F, DCS=1, VBE=0 -> RD A=5 gives DO=8'h30, VBO still 1.
- Entries 2 and 9 both written 8'h7x, valid. CMP DI=8'h70, MSKB=8'hF0 -> HITLINE=16'h0204, HIT=1. Repeat with CBE=1 -> HITLINE=0, HIT=0.
- FLUSH with CS=1 -> HIT=0. Subsequent CMP gives no hit. RD A=2 -> VBO=0, data preserved (DO=8'h7x).
- Priority/hold: WR and CMP in the same cycle -> write performed, HIT unchanged. CS=0 with WR=1 -> memory unchanged. Assert RST_N=0 mid-operation between edges -> outputs 0 immediately, without waiting for CK.
